// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the register-file
// writeback path.
//   DEF_REG_COUNT / DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default geometry
//   reg_addr_t : architectural register index
//   wb_req_t   : one writeback request {valid, addr, data}
//   wb_src_e   : which source won the write port in a given cycle
package regfile_pkg;

  localparam int DEF_REG_COUNT  = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_REG_COUNT);

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

  typedef struct packed {
    logic                      valid;
    reg_addr_t                 addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at MAX and has a synchronous clear.
//   clk, rst_n : clock and asynchronous active-low reset
//   inc_i      : count up by one this cycle (ignored once at MAX)
//   clr_i      : return to zero this cycle (wins over inc_i)
//   cnt_o      : current count
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignment so all flops sample the
  // same pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// ALU and load writeback pipes.
//   clk_i, rst_ni                      : clock, async active-low reset
//   alu_valid_i/alu_ready_o/addr/data  : ALU writeback handshake
//   mem_valid_i/mem_ready_o/addr/data  : load writeback handshake
//   rf_write_en_o/addr_o/data_o        : registered write, one cycle after
//                                        the winning handshake
//   conflict_cnt_o                     : saturating count of cycles with both
//                                        requests valid
// MEM normally wins a tie; after MAX_WAIT consecutive ALU losses the ALU is
// forced through so it cannot starve behind a stream of loads.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int REG_COUNT    = DEF_REG_COUNT,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ZERO_PROTECT = 1,
  parameter int MAX_WAIT     = 4,
  parameter int CNT_WIDTH    = 16,
  localparam int AW          = $clog2(REG_COUNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [AW-1:0]         alu_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [AW-1:0]         mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  rf_write_en_o,
  output logic [AW-1:0]         rf_write_addr_o,
  output logic [DATA_WIDTH-1:0] rf_write_data_o,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  logic [3:0]            wait_cnt;
  logic                  wait_at_max;
  wb_src_e               win_src;

  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  assign wait_at_max = (wait_cnt == 4'(MAX_WAIT));

  // Grant is a pure function of the valids and the starvation count, so the
  // readies never loop back through a requester's valid.
  always_comb begin
    win_src = SRC_NONE;
    if (alu_valid_i && (!mem_valid_i || wait_at_max)) begin
      win_src = SRC_ALU;
    end else if (mem_valid_i) begin
      win_src = SRC_MEM;
    end
  end

  assign alu_ready_o = (win_src == SRC_ALU);
  assign mem_ready_o = (win_src == SRC_MEM);

  // Counts consecutive ALU losses; any cycle the ALU is idle or wins restarts it.
  sat_counter #(
    .WIDTH (4),
    .MAX   (4'(MAX_WAIT))
  ) u_wait_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc_i (alu_valid_i && !alu_ready_o),
    .clr_i (!alu_valid_i || alu_ready_o),
    .cnt_o (wait_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_conflict_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc_i (alu_valid_i && mem_valid_i),
    .clr_i (1'b0),
    .cnt_o (conflict_cnt_o)
  );

  // Payload loads on every handshake; a protected x0 write is accepted and
  // staged but never enabled, so the register file ignores it.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (win_src)
      SRC_ALU: begin
        wr_addr_d = alu_addr_i;
        wr_data_d = alu_data_i;
      end
      SRC_MEM: begin
        wr_addr_d = mem_addr_i;
        wr_data_d = mem_data_i;
      end
      default: ;
    endcase
    if (win_src != SRC_NONE) begin
      wr_en_d = !((ZERO_PROTECT != 0) && (wr_addr_d == '0));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign rf_write_en_o   = wr_en_q;
  assign rf_write_addr_o = wr_addr_q;
  assign rf_write_data_o = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed bench for regfile_wb_arbiter with a small
// register-file model fed from the arbiter's write port.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int AW = DEF_ADDR_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          alu_valid_i, alu_ready_o;
  logic [AW-1:0] alu_addr_i;
  logic [DW-1:0] alu_data_i;
  logic          mem_valid_i, mem_ready_o;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_data_i;
  logic          rf_write_en_o;
  logic [AW-1:0] rf_write_addr_o;
  logic [DW-1:0] rf_write_data_o;
  logic [CW-1:0] conflict_cnt_o;

  regfile_wb_arbiter dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .alu_valid_i     (alu_valid_i),
    .alu_ready_o     (alu_ready_o),
    .alu_addr_i      (alu_addr_i),
    .alu_data_i      (alu_data_i),
    .mem_valid_i     (mem_valid_i),
    .mem_ready_o     (mem_ready_o),
    .mem_addr_i      (mem_addr_i),
    .mem_data_i      (mem_data_i),
    .rf_write_en_o   (rf_write_en_o),
    .rf_write_addr_o (rf_write_addr_o),
    .rf_write_data_o (rf_write_data_o),
    .conflict_cnt_o  (conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Register-file model: x0 is hardwired to zero.
  logic [DW-1:0] rf [DEF_REG_COUNT] = '{default: '0};
  always @(posedge clk_i) begin
    if (rf_write_en_o && (rf_write_addr_o != '0)) rf[rf_write_addr_o] <= rf_write_data_o;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    wb_req_t       alu;
    wb_req_t       mem;
    logic          exp_alu_rdy;
    logic          exp_mem_rdy;
    logic          exp_en;
    reg_addr_t     exp_addr;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic av, input reg_addr_t aa, input logic [DW-1:0] ad,
                              input logic mv, input reg_addr_t ma, input logic [DW-1:0] md,
                              input logic ar, input logic mr, input logic en,
                              input reg_addr_t ea, input logic [DW-1:0] ed, input logic [CW-1:0] ec);
    vec_t v;
    v.alu = '{valid: av, addr: aa, data: ad};
    v.mem = '{valid: mv, addr: ma, data: md};
    v.exp_alu_rdy = ar;
    v.exp_mem_rdy = mr;
    v.exp_en = en;
    v.exp_addr = ea;
    v.exp_data = ed;
    v.exp_cnt = ec;
    return v;
  endfunction

  task automatic drive(input wb_req_t a, input wb_req_t m);
    alu_valid_i = a.valid; alu_addr_i = a.addr; alu_data_i = a.data;
    mem_valid_i = m.valid; mem_addr_i = m.addr; mem_data_i = m.data;
  endtask

  task automatic idle();
    drive('0, '0);
  endtask

  vec_t vecs [9];

  initial begin
    // Consecutive single-cycle vectors from reset; wait_cnt evolves across rows.
    vecs[0] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        16'd0);
    vecs[1] = mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 16'd0);
    vecs[2] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 5'd3,  32'hA5A5A5A5, 16'd0);
    vecs[3] = mk(1'b1, 5'd10, 32'h12345678, 1'b1, 5'd11, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 5'd11, 32'hCAFEF00D, 16'd1);
    vecs[4] = mk(1'b1, 5'd12, 32'h00000011, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd12, 32'h00000011, 16'd1);
    vecs[5] = mk(1'b1, 5'd9,  32'h00000009, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFFFFFF, 16'd2);
    vecs[6] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'hFFFFFFFF, 16'd2);
    vecs[7] = mk(1'b1, 5'd0,  32'h00000005, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h00000005, 16'd2);
    vecs[8] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h00000005, 16'd2);

    idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk_i);
      drive(vecs[i].alu, vecs[i].mem);
      #1;
      check($sformatf("v%0d alu_ready", i), 64'(alu_ready_o), 64'(vecs[i].exp_alu_rdy));
      check($sformatf("v%0d mem_ready", i), 64'(mem_ready_o), 64'(vecs[i].exp_mem_rdy));
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d wr_en", i),   64'(rf_write_en_o),   64'(vecs[i].exp_en));
      check($sformatf("v%0d wr_addr", i), 64'(rf_write_addr_o), 64'(vecs[i].exp_addr));
      check($sformatf("v%0d wr_data", i), 64'(rf_write_data_o), 64'(vecs[i].exp_data));
      check($sformatf("v%0d conflict", i), 64'(conflict_cnt_o), 64'(vecs[i].exp_cnt));
    end
    @(negedge clk_i);
    idle();
    @(posedge clk_i);
    #1;
    check("rf x5",  64'(rf[5]),  64'(32'hDEADBEEF));
    check("rf x3",  64'(rf[3]),  64'(32'hA5A5A5A5));
    check("rf x11", 64'(rf[11]), 64'(32'hCAFEF00D));
    check("rf x12", 64'(rf[12]), 64'(32'h00000011));
    check("rf x0",  64'(rf[0]),  64'(32'h0));

    // Reset with both valids held, then starvation guard on release.
    @(negedge clk_i);
    drive('{valid: 1'b1, addr: 5'd10, data: 32'h12345678},
          '{valid: 1'b1, addr: 5'd11, data: 32'hCAFEF00D});
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("post-reset wr_en", 64'(rf_write_en_o), 64'(1'b0));
    check("post-reset conflict", 64'(conflict_cnt_o), 64'(16'd0));
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin
        @(negedge clk_i);
        #1;
      end
      check($sformatf("starve c%0d alu_ready", c), 64'(alu_ready_o), 64'(c == 5));
      check($sformatf("starve c%0d mem_ready", c), 64'(mem_ready_o), 64'(c != 5));
    end
    @(posedge clk_i);
    #1;
    check("starve wr_en",   64'(rf_write_en_o),   64'(1'b1));
    check("starve wr_addr", 64'(rf_write_addr_o), 64'(5'd10));
    check("starve conflict", 64'(conflict_cnt_o), 64'(16'd5));
    @(negedge clk_i);
    idle();
    @(posedge clk_i);
    #1;
    check("rf x10", 64'(rf[10]), 64'(32'h12345678));

    // Reset pulse between a grant and its commit.
    @(negedge clk_i);
    drive('{valid: 1'b1, addr: 5'd20, data: 32'h00001111}, '0);
    @(posedge clk_i);
    @(negedge clk_i);
    drive('{valid: 1'b1, addr: 5'd20, data: 32'h00002222}, '0);
    @(posedge clk_i);
    #1;
    check("pre-pulse wr_data", 64'(rf_write_data_o), 64'(32'h00002222));
    #1 rst_ni = 1'b0;
    #1;
    check("async clr wr_en", 64'(rf_write_en_o), 64'(1'b0));
    @(negedge clk_i);
    idle();
    @(posedge clk_i);
    #1;
    check("rf x20 kept", 64'(rf[20]), 64'(32'h00001111));
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("release wr_en", 64'(rf_write_en_o), 64'(1'b0));
    @(posedge clk_i);
    #1;
    check("release+1 wr_en", 64'(rf_write_en_o), 64'(1'b0));
    check("rf x20 final", 64'(rf[20]), 64'(32'h00001111));

    // Back-to-back MEM writes to the same register.
    @(negedge clk_i);
    drive('0, '{valid: 1'b1, addr: 5'd7, data: 32'h1});
    #1;
    check("b2b mem_ready 1", 64'(mem_ready_o), 64'(1'b1));
    @(posedge clk_i);
    #1;
    check("b2b wr_en 1",   64'(rf_write_en_o),   64'(1'b1));
    check("b2b wr_data 1", 64'(rf_write_data_o), 64'(32'h1));
    @(negedge clk_i);
    drive('0, '{valid: 1'b1, addr: 5'd7, data: 32'h2});
    @(posedge clk_i);
    #1;
    check("b2b wr_en 2",   64'(rf_write_en_o),   64'(1'b1));
    check("b2b wr_data 2", 64'(rf_write_data_o), 64'(32'h2));
    @(negedge clk_i);
    idle();
    @(posedge clk_i);
    #1;
    check("b2b idle wr_en", 64'(rf_write_en_o), 64'(1'b0));
    check("rf x7", 64'(rf[7]), 64'(32'h2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: the ALU pipe and the load/memory pipe.
- Arbitrates with valid/ready handshakes, using fixed priority plus a starvation guard.
- Registers the winning write into a one-stage output that drives the register_file write port directly.
- Suppresses writes to x0 and counts contention cycles for performance monitoring.

Parameters:
- REG_COUNT, 32, number of architectural registers; address width is $clog2(REG_COUNT).
- DATA_WIDTH, 32, write data width.
- ZERO_PROTECT, 1, when 1 the arbiter drops writes to register 0 after accepting them.
- MAX_WAIT, 4, consecutive losing cycles the ALU tolerates before it is forced to win (1..15).
- CNT_WIDTH, 16, width of the saturating contention counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- alu_valid_i  in  1  ALU writeback request.
- alu_ready_o  out  1  ALU request accepted this cycle.
- alu_addr_i  in  AW  ALU destination register.
- alu_data_i  in  DATA_WIDTH  ALU result.
- mem_valid_i  in  1  load writeback request.
- mem_ready_o  out  1  load request accepted this cycle.
- mem_addr_i  in  AW  load destination register.
- mem_data_i  in  DATA_WIDTH  load data.
- rf_write_en_o  out  1  to register_file write_en_i.
- rf_write_addr_o  out  AW  to register_file write_addr_i.
- rf_write_data_o  out  DATA_WIDTH  to register_file write_data_i.
- conflict_cnt_o  out  CNT_WIDTH  cycles in which both requests were valid, saturating.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - rf_write_en_o=0, rf_write_addr_o=0, rf_write_data_o=0.
  - Starvation counter=0, conflict_cnt_o=0.
  - Any staged write is discarded.
- ready outputs are combinational from the current valids and the starvation counter; they never depend on their own ready.
  - At most one ready is high per cycle.
  - A handshake completes on a rising edge with valid&&ready.
- Requester protocol: valid, addr and data stay stable until ready. The arbiter never backpressures when only one requester is valid.
- Grant rules:
  - Only alu_valid_i: ALU wins.
  - Only mem_valid_i: MEM wins.
  - Both valid: MEM wins, unless wait_cnt==MAX_WAIT, in which case ALU wins.
- wait_cnt update:
  - Increments each cycle ALU is valid and loses, saturating at MAX_WAIT.
  - Clears on an ALU grant, or in any cycle alu_valid_i is low.
- Output stage, one cycle of latency:
  - On a granted handshake at edge N, rf_write_addr_o and rf_write_data_o load the winner's payload.
  - rf_write_en_o=1 during cycle N..N+1; register_file commits it at edge N+1.
  - rf_write_en_o=0 in any cycle following a non-handshake edge. Addr and data hold their previous value.
- Zero protection: with ZERO_PROTECT=1 and winner addr==0, the handshake is still accepted (ready=1) but rf_write_en_o stays 0. With ZERO_PROTECT=0, the write passes through.
- Same-address back-to-back writes: delivered in grant order; the later write wins in the register file.
- conflict_cnt_o increments each cycle with both valids high, saturating at all-ones.
- Reset asserted mid-operation clears the staged write, and no spurious write_en is emitted on release.

Decomposition:
- regfile_pkg:
  - REG_COUNT and DATA_WIDTH defaults.
  - typedef reg_addr_t.
  - typedef wb_req_t struct {valid, addr, data}.
  - enum wb_src_e {SRC_NONE, SRC_ALU, SRC_MEM}.
- One sub-module, sat_counter (parameterised width/max, increment and clear inputs), instantiated for wait_cnt and conflict_cnt.

Test Plan:
- Reset with both valids high, then release -> first cycle after release rf_write_en_o=0, conflict_cnt_o=0.
- ALU only: addr=5, data=32'hDEADBEEF for one cycle -> alu_ready_o=1 the same cycle; next cycle rf_write_en_o=1, addr=5, data=DEADBEEF; register_file read of x5 returns DEADBEEF.
- ALU (addr 10, 32'h12345678) and MEM (addr 11, 32'hCAFEF00D) both held valid -> MEM granted for the first 4 cycles, ALU granted on cycle 5; x10=12345678; conflict_cnt_o=5.
- MEM write addr=0, data=32'hFFFFFFFF -> mem_ready_o=1, rf_write_en_o stays 0, x0 reads 0.
- Grant at edge N, then rst_ni pulsed low before edge N+1 -> rf_write_en_o drops to 0 asynchronously, and the target register keeps its old value.
- MEM writes addr 7 with 32'h1, then 32'h2 on consecutive cycles -> two consecutive rf_write_en_o pulses; x7 reads 32'h2.
